// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types.
// Writeback source encoding matches arbiter requester order.
package cpu_pkg;

  localparam int B_WORD = 32;
  localparam int B_ADRS = 5;
  localparam int N_REGS = 32;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_LOAD,
    WB_MUL
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: search starts at ptr and wraps mod N.
// Pure combinational; reusable for any shared resource.
module rr_arbiter
  import cpu_pkg::*;
#(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [PW:0] j;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr} + (PW+1)'(k);
      if (j >= (PW+1)'(N)) begin
        j = j - (PW+1)'(N);
      end
      if (!found && req[j[PW-1:0]]) begin
        found           = 1'b1;
        gnt[j[PW-1:0]]  = 1'b1;
        idx             = j[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter for writeback sources.
// Registered write output doubles as the forwarding source.
module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int B_WORD = cpu_pkg::B_WORD,
  parameter int B_ADRS = cpu_pkg::B_ADRS
) (
  input  logic                    clk_cpu,
  input  logic                    reset_n,
  input  logic                    lock,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*B_ADRS-1:0] req_adrs,
  input  logic [N_REQ*B_WORD-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    wr_en,
  output logic [B_ADRS-1:0]       wr_adrs,
  output logic [B_WORD-1:0]       wr_data,
  output logic                    fwd_valid,
  output logic [2:0]              grant_idx
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  gnt;
  logic [PW-1:0]     g;
  logic              xfer;
  logic [B_ADRS-1:0] sel_adrs;
  logic [B_WORD-1:0] sel_data;

  logic              wr_en_q, wr_en_d;
  logic [B_ADRS-1:0] wr_adrs_q, wr_adrs_d;
  logic [B_WORD-1:0] wr_data_q, wr_data_d;
  logic [2:0]        gidx_q, gidx_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req_valid & {N_REQ{~lock}}),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (g)
  );

  assign req_ready = reset_n ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);
  assign sel_adrs  = req_adrs[g*B_ADRS +: B_ADRS];
  assign sel_data  = req_data[g*B_WORD +: B_WORD];

  always_comb begin
    wr_en_d   = 1'b0;
    wr_adrs_d = wr_adrs_q;
    wr_data_d = wr_data_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    if (xfer) begin
      // $0 writes are consumed but never reach the file
      wr_en_d   = (sel_adrs != '0);
      wr_adrs_d = sel_adrs;
      wr_data_d = sel_data;
      gidx_d    = 3'(g);
      rr_ptr_d  = (g == PW'(N_REQ-1)) ? '0 : g + 1'b1;
    end
  end

  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_adrs_q <= '0;
      wr_data_q <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_adrs_q <= wr_adrs_d;
      wr_data_q <= wr_data_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_adrs   = wr_adrs_q;
  assign wr_data   = wr_data_q;
  assign fwd_valid = wr_en_q;
  assign grant_idx = gidx_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a
// behavioural register file on the write port.
module tb_regfile_wb_arbiter;
  import cpu_pkg::*;

  logic        clk_cpu = 1'b0;
  logic        reset_n;
  logic        lock;
  logic [2:0]  req_valid;
  logic [14:0] req_adrs;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [4:0]  wr_adrs;
  logic [31:0] wr_data;
  logic        fwd_valid;
  logic [2:0]  grant_idx;

  logic        clr;
  logic [31:0] rf [32];

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.N_REQ(3), .B_WORD(32), .B_ADRS(5)) dut (
    .clk_cpu   (clk_cpu),
    .reset_n   (reset_n),
    .lock      (lock),
    .req_valid (req_valid),
    .req_adrs  (req_adrs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_adrs   (wr_adrs),
    .wr_data   (wr_data),
    .fwd_valid (fwd_valid),
    .grant_idx (grant_idx)
  );

  always #5 clk_cpu = ~clk_cpu;

  always @(posedge clk_cpu or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[wr_adrs] <= wr_data;
    end
  end

  task automatic step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a,
                         input logic [31:0] d);
    req_adrs[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    lock      = 1'b0;
    req_valid = 3'b000;
    req_adrs  = '0;
    req_data  = '0;
    clr       = 1'b1;
    #2 clr    = 1'b0;
    step();
    step();
    req_valid = 3'b111;
    #1;
    n_cmp++;
    if (req_ready !== 3'b000) begin
      n_err++;
      $display("FAIL rst_ready: got %b want 000", req_ready);
    end
    n_cmp++;
    if (wr_en !== 1'b0 || wr_adrs !== 5'd0 || wr_data !== 32'd0
        || grant_idx !== 3'd0) begin
      n_err++;
      $display("FAIL rst_out: got en=%b a=%0d d=%h g=%0d want 0",
               wr_en, wr_adrs, wr_data, grant_idx);
    end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL rst_first_grant: got %b want 001", req_ready);
    end
    req_valid = 3'b000;
    #1;
  endtask

  // rr_ptr 0 -> 1
  task automatic test_single();
    set_req(int'(WB_ALU), 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL single_ready: got %b want 001", req_ready);
    end
    step();
    req_valid = 3'b000;
    n_cmp++;
    if (wr_en !== 1'b1 || fwd_valid !== 1'b1 || wr_adrs !== 5'd5
        || wr_data !== 32'hDEADBEEF || grant_idx !== 3'd0) begin
      n_err++;
      $display("FAIL single_wr: got en=%b fv=%b a=%0d d=%h g=%0d want 1 1 5 deadbeef 0",
               wr_en, fwd_valid, wr_adrs, wr_data, grant_idx);
    end
    step();
    n_cmp++;
    if (wr_en !== 1'b0 || wr_adrs !== 5'd5) begin
      n_err++;
      $display("FAIL single_idle: got en=%b a=%0d want 0 5", wr_en, wr_adrs);
    end
    n_cmp++;
    if (rf[5] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL single_commit: got %h want deadbeef", rf[5]);
    end
  endtask

  // rr_ptr starts at 1: order 1,2,0,1,2,0; ends at 1
  task automatic test_round_robin();
    int exp_g [6] = '{1, 2, 0, 1, 2, 0};
    set_req(0, 5'd1, 32'hA0000000);
    set_req(1, 5'd2, 32'hA0000001);
    set_req(2, 5'd3, 32'hA0000002);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (req_ready !== 3'(1 << exp_g[i])) begin
        n_err++;
        $display("FAIL rr_ready[%0d]: got %b want idx %0d",
                 i, req_ready, exp_g[i]);
      end
      step();
      n_cmp++;
      if (wr_en !== 1'b1 || grant_idx !== 3'(exp_g[i])
          || wr_adrs !== 5'(exp_g[i] + 1)
          || wr_data !== 32'hA0000000 + 32'(exp_g[i])) begin
        n_err++;
        $display("FAIL rr_wr[%0d]: got en=%b g=%0d a=%0d d=%h want g=%0d",
                 i, wr_en, grant_idx, wr_adrs, wr_data, exp_g[i]);
      end
    end
    req_valid = 3'b000;
    step();
  endtask

  // rr_ptr 1 -> 2
  task automatic test_zero_reg();
    set_req(int'(WB_LOAD), 5'd0, 32'h00001234);
    req_valid = 3'b010;
    #1;
    n_cmp++;
    if (req_ready !== 3'b010) begin
      n_err++;
      $display("FAIL zero_ready: got %b want 010", req_ready);
    end
    step();
    req_valid = 3'b000;
    n_cmp++;
    if (wr_en !== 1'b0 || grant_idx !== 3'd1 || wr_adrs !== 5'd0
        || wr_data !== 32'h00001234) begin
      n_err++;
      $display("FAIL zero_wr: got en=%b g=%0d a=%0d d=%h want 0 1 0 1234",
               wr_en, grant_idx, wr_adrs, wr_data);
    end
    req_valid = 3'b111;
    #1;
    n_cmp++;
    if (req_ready !== 3'b100) begin
      n_err++;
      $display("FAIL zero_ptr: got %b want 100", req_ready);
    end
    req_valid = 3'b000;
    #1;
    n_cmp++;
    if (rf[0] !== 32'd0) begin
      n_err++;
      $display("FAIL zero_rf: got %h want 0", rf[0]);
    end
  endtask

  // rr_ptr 2 -> grant 2 -> 0, lock, resume at 0 -> 1
  task automatic test_lock();
    set_req(0, 5'd10, 32'hB0);
    set_req(1, 5'd11, 32'hB1);
    set_req(2, 5'd12, 32'hB2);
    req_valid = 3'b111;
    step();
    lock = 1'b1;
    #1;
    n_cmp++;
    if (wr_en !== 1'b1 || grant_idx !== 3'd2 || req_ready !== 3'b000) begin
      n_err++;
      $display("FAIL lock_drain: got en=%b g=%0d rdy=%b want 1 2 000",
               wr_en, grant_idx, req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (wr_en !== 1'b0 || req_ready !== 3'b000) begin
        n_err++;
        $display("FAIL lock_hold[%0d]: got en=%b rdy=%b want 0 000",
                 i, wr_en, req_ready);
      end
    end
    lock = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL lock_resume: got %b want 001", req_ready);
    end
    step();
    req_valid = 3'b000;
    n_cmp++;
    if (wr_en !== 1'b1 || grant_idx !== 3'd0 || wr_data !== 32'hB0) begin
      n_err++;
      $display("FAIL lock_resume_wr: got en=%b g=%0d d=%h want 1 0 b0",
               wr_en, grant_idx, wr_data);
    end
    step();
  endtask

  // rr_ptr 1: LOAD handshake then reset before the commit edge
  task automatic test_midop_reset();
    set_req(1, 5'd9, 32'h00000055);
    req_valid = 3'b010;
    #1;
    n_cmp++;
    if (req_ready !== 3'b010) begin
      n_err++;
      $display("FAIL midrst_ready: got %b want 010", req_ready);
    end
    @(posedge clk_cpu);
    #1 reset_n = 1'b0;
    req_valid = 3'b000;
    #1;
    n_cmp++;
    if (wr_en !== 1'b0 || wr_adrs !== 5'd0 || grant_idx !== 3'd0) begin
      n_err++;
      $display("FAIL midrst_out: got en=%b a=%0d g=%0d want 0 0 0",
               wr_en, wr_adrs, grant_idx);
    end
    step();
    step();
    n_cmp++;
    if (rf[9] !== 32'd0) begin
      n_err++;
      $display("FAIL midrst_rf: got %h want 0", rf[9]);
    end
    reset_n = 1'b1;
    req_valid = 3'b110;
    #1;
    n_cmp++;
    if (req_ready !== 3'b010) begin
      n_err++;
      $display("FAIL midrst_ptr: got %b want 010", req_ready);
    end
    req_valid = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_reg();
    test_lock();
    test_midop_reset();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish by 100000");
    $fatal(1);
  end

endmodule
